// File: rtl/window_gen_pkg.sv
// Shared definitions for the 3x3 window generator and its downstream filter.
package window_gen_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned WIN_N      = 9;

  // Row-major window slots, p1 = top-left, p9 = bottom-right (current pixel).
  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned P3 = 2;
  localparam int unsigned P4 = 3;
  localparam int unsigned P5 = 4;
  localparam int unsigned P6 = 5;
  localparam int unsigned P7 = 6;
  localparam int unsigned P8 = 7;
  localparam int unsigned P9 = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/window_gen3x3_row_delay.sv
// One-row delay line: single-port circular RAM, combinational read of the old
// word and write of the new word at the same address on each accept.
module row_delay #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  // Contents are deliberately not reset; readers gate on stream position.
  logic [DW-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_gen3x3.sv
// Raster-stream 3x3 neighbourhood generator: emits the window whose
// bottom-right corner is each accepted interior pixel.
module window_gen3x3
  import window_gen_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_pixel,
  output logic          out_valid,
  output logic [DW-1:0] win_p1,
  output logic [DW-1:0] win_p2,
  output logic [DW-1:0] win_p3,
  output logic [DW-1:0] win_p4,
  output logic [DW-1:0] win_p5,
  output logic [DW-1:0] win_p6,
  output logic [DW-1:0] win_p7,
  output logic [DW-1:0] win_p8,
  output logic [DW-1:0] win_p9,
  output logic          frame_done,
  output logic          busy
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col, col_nxt, pos_col;
  logic [ROW_W-1:0] row, row_nxt, pos_row;
  logic             accept;
  logic             last;
  logic             emit;

  state_t state, state_nxt;
  logic   busy_nxt;

  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic [DW-1:0] sr0 [2];
  logic [DW-1:0] sr1 [2];
  logic [DW-1:0] sr2 [2];
  logic [DW-1:0] win_nxt [WIN_N];
  logic [DW-1:0] win_q   [WIN_N];

  // in_sof relocates the current pixel to (0,0) regardless of the counters.
  assign accept  = en & in_valid;
  assign pos_col = in_sof ? '0 : col;
  assign pos_row = in_sof ? '0 : row;
  assign last    = (pos_row == ROW_W'(IMG_H - 1)) && (pos_col == COL_W'(IMG_W - 1));
  assign emit    = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

  // Position of the pixel after the current one.
  always_comb begin
    col_nxt = pos_col + COL_W'(1);
    row_nxt = pos_row;
    if (last) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (pos_col == COL_W'(IMG_W - 1)) begin
      col_nxt = '0;
      row_nxt = pos_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // d1 returns row r-1 at this column, d2 returns row r-2.
  row_delay #(
    .DEPTH (IMG_W),
    .DW    (DW)
  ) u_row1 (
    .clk     (clk),
    .we      (accept),
    .addr    (pos_col),
    .wr_data (in_pixel),
    .rd_data (d1)
  );

  row_delay #(
    .DEPTH (IMG_W),
    .DW    (DW)
  ) u_row2 (
    .clk     (clk),
    .we      (accept),
    .addr    (pos_col),
    .wr_data (d1),
    .rd_data (d2)
  );

  // Column history per window row; index 0 is the previous column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sr0[i] <= '0;
        sr1[i] <= '0;
        sr2[i] <= '0;
      end
    end else if (accept) begin
      sr0[1] <= sr0[0];
      sr1[1] <= sr1[0];
      sr2[1] <= sr2[0];
      sr0[0] <= in_pixel;
      sr1[0] <= d1;
      sr2[0] <= d2;
    end
  end

  always_comb begin
    win_nxt[P1] = sr2[1];
    win_nxt[P2] = sr2[0];
    win_nxt[P3] = d2;
    win_nxt[P4] = sr1[1];
    win_nxt[P5] = sr1[0];
    win_nxt[P6] = d1;
    win_nxt[P7] = sr0[1];
    win_nxt[P8] = sr0[0];
    win_nxt[P9] = in_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_sof) begin
        state_nxt = FILL;
      end else begin
        case (state)
          IDLE:    state_nxt = FILL;
          FILL:    if (row_nxt == ROW_W'(2)) state_nxt = RUN;
          RUN:     if (last) state_nxt = DONE;
          DONE:    state_nxt = FILL;
          default: state_nxt = IDLE;
        endcase
      end
    end else if (en && (state == DONE)) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    busy_nxt = 1'b0;
    if (state_nxt != IDLE) begin
      busy_nxt = 1'b1;
    end
  end

  // Window bytes hold their last value whenever no window is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < int'(WIN_N); i++) begin
        win_q[i] <= '0;
      end
    end else begin
      out_valid  <= accept & emit;
      frame_done <= accept & last;
      busy       <= busy_nxt;
      if (accept & emit) begin
        for (int i = 0; i < int'(WIN_N); i++) begin
          win_q[i] <= win_nxt[i];
        end
      end
    end
  end

  assign win_p1 = win_q[P1];
  assign win_p2 = win_q[P2];
  assign win_p3 = win_q[P3];
  assign win_p4 = win_q[P4];
  assign win_p5 = win_q[P5];
  assign win_p6 = win_q[P6];
  assign win_p7 = win_q[P7];
  assign win_p8 = win_q[P8];
  assign win_p9 = win_q[P9];

endmodule

// File: tb/tb_window_gen3x3.sv
// Bench for window_gen3x3: a 4x4 instance against an image-array model, plus a
// full 256x256 instance streamed concurrently and checked window by window.
module tb_window_gen3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small 4x4 instance ----------------
  logic       rst_n = 1'b0;
  logic       en = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic       out_valid, frame_done, busy;
  logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic [71:0] dut_win;
  assign dut_win = {w1, w2, w3, w4, w5, w6, w7, w8, w9};

  window_gen3x3 #(.IMG_W(4), .IMG_H(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(out_valid),
    .win_p1(w1), .win_p2(w2), .win_p3(w3), .win_p4(w4), .win_p5(w5),
    .win_p6(w6), .win_p7(w7), .win_p8(w8), .win_p9(w9),
    .frame_done(frame_done), .busy(busy)
  );

  // ---------------- large 256x256 instance ----------------
  logic       brst_n = 1'b0;
  logic       ben = 1'b0, bvalid = 1'b0, bsof = 1'b0;
  logic [7:0] bpixel = 8'd0;
  logic       bout_valid, bfd, bbusy;
  logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic [71:0] bwin;
  assign bwin = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

  window_gen3x3 #(.IMG_W(256), .IMG_H(256), .DW(8)) dut_big (
    .clk(clk), .rst_n(brst_n), .en(ben), .in_valid(bvalid), .in_sof(bsof),
    .in_pixel(bpixel), .out_valid(bout_valid),
    .win_p1(b1), .win_p2(b2), .win_p3(b3), .win_p4(b4), .win_p5(b5),
    .win_p6(b6), .win_p7(b7), .win_p8(b8), .win_p9(b9),
    .frame_done(bfd), .busy(bbusy)
  );

  int errors = 0;
  int checks = 0;

  // Model of the small instance: the frame as a 2D image and the stream position.
  logic [7:0]  img [4][4];
  int          mr = 0, mc = 0;
  logic        nxt_valid = 1'b0, nxt_fd = 1'b0;
  logic [71:0] nxt_win = '0;
  logic        exp_valid, exp_fd;
  logic [71:0] exp_win;
  logic [72:0] dut_log [$];

  // Expected outputs become visible one edge after the accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_fd    <= 1'b0;
      exp_win   <= '0;
    end else begin
      exp_valid <= nxt_valid;
      exp_fd    <= nxt_fd;
      exp_win   <= nxt_win;
    end
  end

  // Hand-computed windows of the 4x4 ramp 4r+c.
  logic [71:0] lits0 [4] = '{
    {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10},
    {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11},
    {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14},
    {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}
  };
  logic [71:0] lit_s100 = {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110};
  logic [71:0] lit_p50  = {8'd50, 8'd51, 8'd52, 8'd54, 8'd55, 8'd56, 8'd58, 8'd59, 8'd60};

  // Large-instance tracking.
  int bkr = 2, bkc = 2, bcount = 0, bfd_count = 0;
  bit big_done = 1'b0;

  function automatic logic [7:0] bpix(input int r, input int c);
    return 8'((r * 13 + c * 7) % 256);
  endfunction

  function automatic logic [71:0] bwin_exp(input int r, input int c);
    logic [71:0] w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w = {w[63:0], bpix(r - 2 + dr, c - 2 + dc)};
    return w;
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of both instances against their references.
  task automatic compare_all();
    check("out_valid", 73'(out_valid), 73'(exp_valid));
    check("frame_done", 73'(frame_done), 73'(exp_fd));
    check("window", 73'(dut_win), 73'(exp_win));
    check("valid_with_en_low", 73'(out_valid & ~en), 73'(0));
    if (out_valid) dut_log.push_back({frame_done, dut_win});
    if (bfd) bfd_count++;
    if (bout_valid) begin
      check("big_window", 73'(bwin), 73'(bwin_exp(bkr, bkc)));
      check("big_frame_done", 73'(bfd), 73'((bkr == 255) && (bkc == 255)));
      bcount++;
      bkc++;
      if (bkc == 256) begin
        bkc = 2;
        bkr++;
      end
    end
  endtask

  task automatic model_step(input logic e, input logic v, input logic s, input logic [7:0] p);
    nxt_valid = 1'b0;
    nxt_fd    = 1'b0;
    nxt_win   = exp_win;
    if (rst_n && e && v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        nxt_valid = 1'b1;
        nxt_win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                   img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                   img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
        nxt_fd = (mr == 3 && mc == 3);
      end
      mc++;
      if (mc == 4) begin
        mc = 0;
        mr = (mr == 3) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic tick(input logic e, input logic v, input logic s, input logic [7:0] p);
    @(posedge clk);
    #1;
    compare_all();
    en = e; in_valid = v; in_sof = s; in_pixel = p;
    model_step(e, v, s, p);
  endtask

  task automatic flush();
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_gap();
    repeat ($urandom_range(0, 3)) begin
      case ($urandom_range(0, 2))
        0:       tick(1'b0, 1'b1, 1'($urandom), 8'($urandom));
        1:       tick(1'b1, 1'b0, 1'($urandom), 8'($urandom));
        default: tick(1'b0, 1'b0, 1'b0, 8'($urandom));
      endcase
    end
  endtask

  task automatic run_pixels(input int base, input int count, input bit sof_first, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (gaps) do_gap();
      tick(1'b1, 1'b1, sof_first && (k == 0), 8'(base + k));
    end
  endtask

  task automatic check_lits0(input int offset);
    for (int i = 0; i < 4; i++)
      if (dut_log.size() > offset + i)
        check("logged_window", dut_log[offset + i], {(i == 3) ? 1'b1 : 1'b0, lits0[i]});
  endtask

  // Large instance: one continuous ramp frame.
  initial begin
    repeat (3) @(posedge clk);
    #1 brst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
      #1;
      ben = 1'b1; bvalid = 1'b1; bsof = (i == 0);
      bpixel = bpix(i / 256, i % 256);
    end
    @(posedge clk);
    #1 bvalid = 1'b0; bsof = 1'b0;
    repeat (4) @(posedge clk);
    big_done = 1'b1;
  end

  initial begin
    int guard;
    // Reset state
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_out_valid", 73'(out_valid), 73'(0));
    check("reset_busy", 73'(busy), 73'(0));
    check("reset_window", 73'(dut_win), 73'(0));
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 8'd0);

    // One continuous frame
    dut_log.delete();
    run_pixels(0, 6, 1'b1, 1'b0);
    check("busy_mid_frame", 73'(busy), 73'(1));
    for (int k = 6; k < 16; k++) tick(1'b1, 1'b1, 1'b0, 8'(k));
    flush();
    check("busy_after_frame", 73'(busy), 73'(0));
    check("frame1_count", 73'(dut_log.size()), 73'(4));
    check_lits0(0);

    // Same frame with random gaps and en-low cycles
    dut_log.delete();
    run_pixels(0, 16, 1'b1, 1'b1);
    flush();
    check("gapped_count", 73'(dut_log.size()), 73'(4));
    check_lits0(0);

    // Back-to-back frames, second one offset by 100
    dut_log.delete();
    run_pixels(0, 16, 1'b1, 1'b0);
    run_pixels(100, 16, 1'b1, 1'b0);
    flush();
    check("b2b_count", 73'(dut_log.size()), 73'(8));
    if (dut_log.size() == 8) begin
      check("b2b_first_fd", dut_log[3], {1'b1, lits0[3]});
      check("b2b_second_first", dut_log[4], {1'b0, lit_s100});
      check("b2b_second_fd", 73'(dut_log[7][72]), 73'(1));
    end

    // Reset after pixel 9, then a frame without in_sof
    dut_log.delete();
    run_pixels(0, 10, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    check("busy_before_reset", 73'(busy), 73'(1));
    rst_n = 1'b0;
    mr = 0; mc = 0;
    nxt_valid = 1'b0; nxt_fd = 1'b0; nxt_win = '0;
    #1;
    check("async_reset_busy", 73'(busy), 73'(0));
    check("async_reset_valid", 73'(out_valid), 73'(0));
    check("async_reset_window", 73'(dut_win), 73'(0));
    repeat (2) tick(1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    run_pixels(0, 16, 1'b0, 1'b0);
    flush();
    check("post_reset_count", 73'(dut_log.size()), 73'(4));
    check_lits0(0);

    // in_sof at pixel 6 of a partial frame
    dut_log.delete();
    run_pixels(50, 6, 1'b1, 1'b0);
    run_pixels(0, 16, 1'b1, 1'b0);
    flush();
    check("sof6_count", 73'(dut_log.size()), 73'(4));
    check_lits0(0);

    // in_sof after the partial frame already emitted one window
    dut_log.delete();
    run_pixels(50, 11, 1'b1, 1'b0);
    run_pixels(0, 16, 1'b1, 1'b1);
    flush();
    check("sof11_count", 73'(dut_log.size()), 73'(5));
    if (dut_log.size() == 5) begin
      check("sof11_partial", dut_log[0], {1'b0, lit_p50});
      check_lits0(1);
    end

    // Random pixels, gaps and occasional restarts
    for (int n = 0; n < 400; n++) begin
      do_gap();
      tick(1'b1, 1'b1, (n == 0) || ($urandom_range(0, 59) == 0), 8'($urandom));
    end
    flush();

    // Wait for the large frame to drain
    guard = 0;
    while (!big_done && guard < 80000) begin
      tick(1'b1, 1'b0, 1'b0, 8'd0);
      guard++;
    end
    check("big_finished", 73'(big_done), 73'(1));
    check("big_window_count", 73'(bcount), 73'(64516));
    check("big_frame_done_count", 73'(bfd_count), 73'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
